// File: rtl/pixel_stream_feeder.sv
// pixel_stream_feeder
// Streams one frame from a synchronous frame-buffer RAM into the canny_edge
// slave stream. The first burst of LINES_PER_BURST lines goes out as soon as
// start is accepted. Each later burst waits for a rising edge on the filter
// interrupt. After the image, PAD_BURSTS zero-filled bursts flush the
// filter's line buffers.
//
// Ports:
//   axi_clk, axi_rst      clock, asynchronous active-high reset
//   start                 one-cycle pulse, starts a frame when idle
//   interrupt             filter interrupt, each rising edge grants one burst
//   mem_rd_en/mem_addr    RAM read strobe and linear raster address
//   mem_rd_data           RAM data, valid one cycle after mem_rd_en
//   pixel_out_valid/pixel_out/pixel_out_ready   valid/ready pixel stream
//   busy                  frame in progress
//   done                  one-cycle pulse after the last pad pixel
//   overrun               sticky, set when a grant arrives while one is pending
module pixel_stream_feeder #(
  parameter int IMG_W           = 256,
  parameter int IMG_H           = 256,
  parameter int LINES_PER_BURST = 4,
  parameter int PAD_BURSTS      = 2,
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 8
) (
  input  logic              axi_clk,
  input  logic              axi_rst,
  input  logic              start,
  input  logic              interrupt,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              pixel_out_valid,
  output logic [DATA_W-1:0] pixel_out,
  input  logic              pixel_out_ready,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int BL   = IMG_W * LINES_PER_BURST;
  localparam int NB   = IMG_H / LINES_PER_BURST;
  localparam int TOT  = NB + PAD_BURSTS;
  localparam int NPIX = IMG_W * IMG_H;
  localparam int CW   = $clog2(BL + 1);
  localparam int BW   = $clog2(TOT + 1);

  localparam logic [CW-1:0]     BL_C     = CW'(BL);
  localparam logic [CW-1:0]     BL_M1    = CW'(BL - 1);
  localparam logic [BW-1:0]     NB_C     = BW'(NB);
  localparam logic [BW-1:0]     LAST_B   = BW'(TOT - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(NPIX - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_BURST    = 2'd1,
    S_WAIT_INT = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [CW-1:0]       r_issue_cnt;
  logic [CW-1:0]       r_xfer_cnt;
  logic [BW-1:0]       r_burst_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_int_d;
  logic                r_int_q;
  logic                r_grant;
  logic                r_overrun;
  logic                r_inflight;
  logic [DATA_W-1:0]   r_fifo [0:1];
  logic                r_wr_ptr;
  logic                r_rd_ptr;
  logic [1:0]          r_fifo_cnt;

  logic                w_pad;
  logic [1:0]          w_occ;
  logic                w_issue;
  logic [DATA_W-1:0]   w_arr_data;
  logic                w_valid;
  logic [DATA_W-1:0]   w_data;
  logic                w_fire;
  logic                w_push;
  logic                w_pop;
  logic                w_last;
  logic                w_int_edge;
  logic                w_start_go;
  logic                w_burst_go;

  // Pad bursts are those whose index is past the image.
  assign w_pad      = (r_burst_cnt >= NB_C);
  // Buffered plus in-flight pixels; reads stop when both FIFO slots are spoken for.
  assign w_occ      = r_fifo_cnt + {1'b0, r_inflight};
  // Pad bursts issue "virtual" reads (no RAM strobe) so the zeros follow the
  // same pipeline timing and backpressure handling as image pixels.
  assign w_issue    = (r_state == S_BURST) && (r_issue_cnt < BL_C) && (w_occ < 2'd2);
  assign w_arr_data = w_pad ? {DATA_W{1'b0}} : mem_rd_data;

  // A pixel arriving this cycle is presented directly when the FIFO is empty.
  assign w_valid    = (r_fifo_cnt != 2'd0) || r_inflight;
  assign w_fire     = w_valid && pixel_out_ready;
  assign w_push     = r_inflight && !((r_fifo_cnt == 2'd0) && w_fire);
  assign w_pop      = w_fire && (r_fifo_cnt != 2'd0);
  assign w_last     = (r_state == S_BURST) && w_fire && (r_xfer_cnt == BL_M1);

  assign w_int_edge = r_int_d && !r_int_q &&
                      ((r_state == S_BURST) || (r_state == S_WAIT_INT));
  assign w_start_go = (r_state == S_IDLE) && start;
  assign w_burst_go = (r_state == S_WAIT_INT) && r_grant;

  // Stream data selection: FIFO head, else the pixel arriving this cycle.
  always_comb begin
    w_data = {DATA_W{1'b0}};
    if (r_fifo_cnt != 2'd0) begin
      w_data = r_fifo[r_rd_ptr];
    end else if (r_inflight) begin
      w_data = w_arr_data;
    end else begin
      w_data = {DATA_W{1'b0}};
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_BURST;
        else       w_state_nxt = S_IDLE;
      end
      S_BURST: begin
        if (w_last) begin
          if (r_burst_cnt == LAST_B) w_state_nxt = S_DONE;
          else                       w_state_nxt = S_WAIT_INT;
        end else begin
          w_state_nxt = S_BURST;
        end
      end
      S_WAIT_INT: begin
        if (r_grant) w_state_nxt = S_BURST;
        else         w_state_nxt = S_WAIT_INT;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Per-burst read/transfer counters, burst index and RAM address.
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      r_issue_cnt <= '0;
      r_xfer_cnt  <= '0;
      r_burst_cnt <= '0;
      r_addr      <= '0;
    end else if (w_start_go) begin
      r_issue_cnt <= '0;
      r_xfer_cnt  <= '0;
      r_burst_cnt <= '0;
      r_addr      <= '0;
    end else if (w_last) begin
      // Pipeline is empty here: all BL reads were issued and consumed.
      r_issue_cnt <= '0;
      r_xfer_cnt  <= '0;
      if (r_burst_cnt != LAST_B) r_burst_cnt <= r_burst_cnt + BW'(1);
    end else begin
      if (w_issue) r_issue_cnt <= r_issue_cnt + CW'(1);
      if (w_fire)  r_xfer_cnt  <= r_xfer_cnt + CW'(1);
      // Hold at the last pixel so the address never leaves the frame.
      if (w_issue && !w_pad && (r_addr != ADDR_MAX)) r_addr <= r_addr + ADDR_W'(1);
    end
  end

  // Interrupt synchroniser/edge history, grant flag and sticky overrun.
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      r_int_d   <= 1'b0;
      r_int_q   <= 1'b0;
      r_grant   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_int_d <= interrupt;
      r_int_q <= r_int_d;
      if (w_start_go) begin
        r_grant   <= 1'b0;
        r_overrun <= 1'b0;
      end else if (w_int_edge && r_grant) begin
        // Grants do not queue: the extra edge is only recorded.
        r_overrun <= 1'b1;
        if (w_burst_go) r_grant <= 1'b0;
      end else if (w_int_edge) begin
        r_grant <= 1'b1;
      end else if (w_burst_go) begin
        r_grant <= 1'b0;
      end else begin
        r_grant <= r_grant;
      end
    end
  end

  // Two-entry output FIFO and read-in-flight tracking.
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      r_fifo[0]  <= '0;
      r_fifo[1]  <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_fifo_cnt <= 2'd0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_arr_data;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_fifo_cnt <= r_fifo_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign mem_rd_en       = w_issue && !w_pad;
  assign mem_addr        = r_addr;
  assign pixel_out_valid = w_valid;
  assign pixel_out       = w_data;
  assign busy            = (r_state == S_BURST) || (r_state == S_WAIT_INT);
  assign done            = (r_state == S_DONE);
  assign overrun         = r_overrun;

endmodule

// File: tb/tb_pixel_stream_feeder.sv
module tb_pixel_stream_feeder;

  localparam int IMG_W  = 8;
  localparam int IMG_H  = 8;
  localparam int LPB    = 4;
  localparam int PADB   = 2;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int BL     = IMG_W * LPB;          // 32
  localparam int NPIX   = IMG_W * IMG_H;        // 64
  localparam int NBT    = IMG_H / LPB + PADB;   // 4 bursts
  localparam int TOTAL  = NBT * BL;             // 128 transfers

  logic              axi_clk   = 1'b0;
  logic              axi_rst   = 1'b1;
  logic              start     = 1'b0;
  logic              interrupt = 1'b0;
  logic              ready     = 1'b0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data = '0;
  logic              pv;
  logic [DATA_W-1:0] pd;
  logic              busy;
  logic              done;
  logic              overrun;

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int exp_idx   = 0;
  int allowed   = 0;
  int start_cyc = 0;
  int int_cyc   = 0;
  int end_cyc   = 0;
  int done_cnt  = 0;
  int max_addr  = 0;
  int chk_mode  = 0;
  bit mon_en    = 1'b0;
  bit rnd_ready = 1'b0;

  pixel_stream_feeder #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .LINES_PER_BURST(LPB),
    .PAD_BURSTS(PADB), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .axi_clk(axi_clk), .axi_rst(axi_rst), .start(start), .interrupt(interrupt),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .pixel_out_valid(pv), .pixel_out(pd), .pixel_out_ready(ready),
    .busy(busy), .done(done), .overrun(overrun)
  );

  initial forever #5 axi_clk = ~axi_clk;

  always @(posedge axi_clk) cyc <= cyc + 1;

  // Frame-buffer RAM model: RAM[a] = a, one-cycle read latency.
  always @(posedge axi_clk) if (mem_rd_en) mem_rd_data <= mem_addr[DATA_W-1:0];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  // Ready driver: always 1, or a fair coin when rnd_ready is set.
  initial forever begin
    @(posedge axi_clk);
    #1;
    ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Reference model: transfer n of a frame carries pixel n for the image
  // part and 0 for the pad part; burst n/BL may only flow once granted.
  initial begin
    logic              prev_v;
    logic              prev_r;
    logic [DATA_W-1:0] prev_d;
    logic [DATA_W-1:0] expv;
    prev_v = 1'b0;
    prev_r = 1'b0;
    prev_d = '0;
    forever begin
      @(negedge axi_clk);
      if (axi_rst || !mon_en) begin
        prev_v = 1'b0;
      end else begin
        checks++;
        if (int'(mem_addr) > NPIX - 1) begin
          failures++;
          $display("FAIL addr_range actual=%0d required<=%0d", mem_addr, NPIX - 1);
        end
        if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
        if (done) done_cnt++;
        if (prev_v && !prev_r) begin
          checks++;
          if (!(pv && pd == prev_d)) begin
            failures++;
            $display("FAIL stall_hold actual=v%0d/d%0d required=v1/d%0d", pv, pd, prev_d);
          end
        end
        if (pv && ready) begin
          expv = (exp_idx < NPIX) ? 8'(exp_idx) : 8'd0;
          checks++;
          if (exp_idx >= TOTAL) begin
            failures++;
            $display("FAIL extra_transfer actual=%0d required<%0d", exp_idx, TOTAL);
          end else if (pd !== expv) begin
            failures++;
            $display("FAIL pixel[%0d] actual=%0d required=%0d", exp_idx, pd, expv);
          end
          checks++;
          if (exp_idx / BL >= allowed) begin
            failures++;
            $display("FAIL ungranted_burst idx=%0d actual_burst=%0d required<%0d",
                     exp_idx, exp_idx / BL, allowed);
          end
          if (exp_idx == 45)  chk("pin_pixel45", int'(pd), 45);
          if (exp_idx == 100) chk("pin_pad100", int'(pd), 0);
          if (exp_idx % BL == 0) begin
            if (chk_mode == 1 && exp_idx == 0) chk("start_latency", cyc - start_cyc, 2);
            if (chk_mode == 1 && exp_idx != 0) chk("int_latency", cyc - int_cyc, 4);
            if (chk_mode == 2 && exp_idx == BL) chk("back_to_back_gap", cyc - end_cyc, 3);
          end
          if (exp_idx % BL == BL - 1) end_cyc = cyc;
          exp_idx++;
        end
        prev_v = pv;
        prev_d = pd;
        prev_r = ready;
      end
    end
  end

  task automatic do_start();
    exp_idx   = 0;
    allowed   = 1;
    done_cnt  = 0;
    max_addr  = 0;
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    start     = 1'b0;
  endtask

  task automatic pulse_int(input bit grant);
    interrupt = 1'b1;
    int_cyc   = cyc;
    if (grant) allowed++;
    tick();
    interrupt = 1'b0;
  endtask

  task automatic wait_xfers(input int n, input int budget);
    int k;
    k = 0;
    while (exp_idx < n && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (exp_idx < n) begin
      failures++;
      $display("FAIL timeout_xfers actual=%0d required=%0d", exp_idx, n);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_valid"}, int'(pv), 0);
    chk({tag, "_data"}, int'(pd), 0);
    chk({tag, "_rd_en"}, int'(mem_rd_en), 0);
    chk({tag, "_addr"}, int'(mem_addr), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_overrun"}, int'(overrun), 0);
  endtask

  task automatic finish_frame(input int exp_ovr);
    wait_xfers(TOTAL, 4000);
    repeat (6) tick();
    chk("transfer_count", exp_idx, TOTAL);
    chk("done_pulses", done_cnt, 1);
    chk("busy_after_done", int'(busy), 0);
    chk("overrun_end", int'(overrun), exp_ovr);
    chk("max_addr", max_addr, NPIX - 1);
  endtask

  task automatic normal_frame(input bit midstart);
    int vbad;
    do_start();
    for (int b = 1; b < NBT; b++) begin
      wait_xfers(b * BL, 4000);
      vbad = 0;
      repeat (20) begin
        tick();
        if (pv) vbad++;
      end
      chk("valid_low_between_bursts", vbad, 0);
      if (midstart && b == 2) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      pulse_int(1'b1);
    end
    finish_frame(0);
  endtask

  initial begin
    int vbad;
    axi_rst = 1'b1;
    repeat (3) @(posedge axi_clk);
    #1;
    check_outputs_zero("reset");
    axi_rst = 1'b0;
    tick();
    tick();
    mon_en = 1'b1;

    // Full frame, ready high, with an ignored start pulse mid-frame.
    chk_mode = 1;
    normal_frame(1'b1);
    chk_mode = 0;

    // Full frame under random backpressure.
    rnd_ready = 1'b1;
    normal_frame(1'b0);
    rnd_ready = 1'b0;
    tick();

    // Two interrupt edges during burst 0: overrun, burst 1 back-to-back.
    chk_mode = 2;
    do_start();
    wait_xfers(4, 200);
    pulse_int(1'b1);
    tick();
    tick();
    pulse_int(1'b0);
    wait_xfers(BL, 400);
    chk("overrun_set", int'(overrun), 1);
    for (int b = 2; b < NBT; b++) begin
      wait_xfers(b * BL, 400);
      repeat (20) tick();
      pulse_int(1'b1);
    end
    finish_frame(1);
    chk_mode = 0;

    // Missing interrupt stalls the frame; then reset mid burst 1.
    do_start();
    wait_xfers(BL, 400);
    vbad = 0;
    repeat (1000) begin
      tick();
      if (pv || !busy) vbad++;
    end
    chk("stall_valid_low_busy_high", vbad, 0);
    chk("stall_count", exp_idx, BL);
    pulse_int(1'b1);
    wait_xfers(BL + 2, 200);
    pulse_int(1'b1);
    tick();
    tick();
    pulse_int(1'b0);
    wait_xfers(BL + 12, 200);
    tick();
    chk("overrun_before_reset", int'(overrun), 1);
    #2;
    axi_rst = 1'b1;
    #1;
    check_outputs_zero("async_reset");
    repeat (3) tick();
    axi_rst = 1'b0;
    tick();

    // Fresh frame after the abort replays from address 0.
    chk_mode = 1;
    normal_frame(1'b0);
    chk_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
